// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete in one clock; multiply and divide
// run a WIDTH-iteration shift-add / restoring-subtract loop into HI/LO.
//
// state | meaning
// IDLE  | ready; accepts any op, single-cycle ops retire on the next edge
// RUN   | one multiply or divide iteration per cycle, cnt_q counts down to 0
// FIN   | HI/LO/result hold the new values, out_valid pulses, busy still 1
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUop,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shf,
    input  logic [15:0]      immediate,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_XOR   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_NOR   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_LUI   = 5'b01001;
    localparam logic [4:0] OP_SLLV  = 5'b01010;
    localparam logic [4:0] OP_SRA   = 5'b01011;
    localparam logic [4:0] OP_SRAV  = 5'b01100;
    localparam logic [4:0] OP_SLT   = 5'b01101;
    localparam logic [4:0] OP_SRLV  = 5'b01111;
    localparam logic [4:0] OP_MFHI  = 5'b10100;
    localparam logic [4:0] OP_MFLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shv;
    logic             is_multi;
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] iter_acc, iter_mq;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    assign busy      = (state_q != IDLE);
    assign in_ready  = !busy;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        alu_res = '0;
        shv     = busA[SHW-1:0];
        case (ALUop)
            OP_ADD:  alu_res = busA + B;
            OP_SUB:  alu_res = busA - B;
            OP_XOR:  alu_res = busA ^ B;
            OP_OR:   alu_res = busA | B;
            OP_AND:  alu_res = busA & B;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (busA < B)};
            OP_NOR:  alu_res = ~(busA | B);
            OP_SLL:  alu_res = B << shf;
            OP_SRL:  alu_res = B >> shf;
            OP_LUI:  alu_res = {immediate, {(WIDTH-16){1'b0}}};
            OP_SLLV: alu_res = B << shv;
            OP_SRA:  alu_res = $signed(B) >>> shf;
            OP_SRAV: alu_res = $signed(B) >>> shv;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(busA) < $signed(B))};
            OP_SRLV: alu_res = B >> shv;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MTHI: alu_res = busA;
            OP_MTLO: alu_res = busA;
            default: alu_res = '0;
        endcase
    end

    // Signed ops iterate on magnitudes; the sign is restored when results land in HI/LO.
    always_comb begin
        is_multi = (ALUop[4:2] == 3'b100);
        sgn_a    = ALUop[0] & busA[WIDTH-1];
        sgn_b    = ALUop[0] & B[WIDTH-1];
        abs_a    = sgn_a ? -busA : busA;
        abs_b    = sgn_b ? -B : B;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (is_div_q) begin
            iter_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            iter_mq  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
            iter_acc = mul_sum[WIDTH:1];
            iter_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        prod     = {iter_acc, iter_mq};
        prod_fix = neg_q_q ? -prod : prod;
        if (is_div_q) begin
            fin_lo = neg_q_q ? -iter_mq : iter_mq;
            fin_hi = neg_r_q ? -iter_acc : iter_acc;
        end else begin
            fin_lo = prod_fix[WIDTH-1:0];
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_multi) begin
                        state_d  = RUN;
                        cnt_d    = SHW'(WIDTH-1);
                        acc_d    = '0;
                        mq_d     = abs_a;
                        opnd_d   = abs_b;
                        is_div_d = ALUop[1];
                        // A zero divisor must leave the all-ones quotient unsigned.
                        neg_q_d  = ALUop[1] ? ((sgn_a ^ sgn_b) && (B != '0)) : (sgn_a ^ sgn_b);
                        neg_r_d  = sgn_a;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                        if (ALUop == OP_MTHI) hi_d = busA;
                        if (ALUop == OP_MTLO) lo_d = busA;
                    end
                end
            end
            RUN: begin
                acc_d = iter_acc;
                mq_d  = iter_mq;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d     = FIN;
                    hi_d        = fin_hi;
                    lo_d        = fin_lo;
                    result_d    = fin_lo;
                    zero_d      = (fin_lo == '0);
                    out_valid_d = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32: single-cycle ops, multiply/divide
// timing and results, busy handling and reset abort.
module tb_seq_alu;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_NOR   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_LUI   = 5'b01001;
    localparam logic [4:0] OP_SRAV  = 5'b01100;
    localparam logic [4:0] OP_SLT   = 5'b01101;
    localparam logic [4:0] OP_UNDEF = 5'b01110;
    localparam logic [4:0] OP_MULTU = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_DIVU  = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_MFHI  = 5'b10100;
    localparam logic [4:0] OP_MFLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       ALUop;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shf;
    logic [15:0]      immediate;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int vectors    = 0;
    int miscompares = 0;

    seq_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUop     (ALUop),
        .busA      (busA),
        .B         (B),
        .shf       (shf),
        .immediate (immediate),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Offer one single-cycle op, then check the registered outcome one edge later.
    task automatic single(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [15:0] imm,
                          input logic [31:0] exp);
        chk1({tag, " ready"}, in_ready, 1'b1);
        ALUop = op; busA = a; B = b; shf = sh; immediate = imm; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk1({tag, " out_valid"}, out_valid, 1'b1);
        chk({tag, " result"}, result, exp);
        chk1({tag, " zero"}, zero, (exp == 32'h0));
    endtask

    // Accept a multi-cycle op and watch it to completion; stops in the first
    // cycle in_ready returns. Optionally holds an ADD 1+2 offered while busy.
    task automatic multi(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit hold_add,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, lowcnt, pulses;
        logic [31:0] res_at_pulse;
        chk1({tag, " ready"}, in_ready, 1'b1);
        ALUop = op; busA = a; B = b; in_valid = 1'b1;
        step();
        if (hold_add) begin
            ALUop = OP_ADD; busA = 32'h1; B = 32'h2;
        end else begin
            in_valid = 1'b0; busA = 32'h5A5A_1234; B = 32'h0F0F_0F0F;
        end
        lat = 0; lowcnt = 0; pulses = 0; res_at_pulse = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            if (!in_ready) lowcnt++;
            if (out_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    res_at_pulse = result;
                end
            end
            if (in_ready) break;
            step();
        end
        chk({tag, " latency"}, lat, 32'd33);
        chk({tag, " ready_low_cycles"}, lowcnt, 32'd33);
        chk({tag, " pulses"}, pulses, 32'd1);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " result"}, res_at_pulse, exp_lo);
        if (hold_add) begin
            step();
            in_valid = 1'b0;
            chk1({tag, " held add out_valid"}, out_valid, 1'b1);
            chk({tag, " held add result"}, result, 32'h3);
        end
    endtask

    initial begin
        int pulses;
        reset = 1'b1; in_valid = 1'b0; ALUop = 5'd0; busA = '0; B = '0;
        shf = '0; immediate = '0;
        step();
        in_valid = 1'b1;
        step();
        chk1("rst out_valid", out_valid, 1'b0);
        chk("rst result", result, 32'h0);
        chk1("rst zero", zero, 1'b1);
        chk("rst hi", hi, 32'h0);
        chk("rst lo", lo, 32'h0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        reset = 1'b0;

        single("add wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 16'h0, 32'h0);
        step();
        chk1("idle out_valid", out_valid, 1'b0);
        chk("idle result hold", result, 32'h0);
        single("sub", OP_SUB, 32'h5, 32'h7, 5'd0, 16'h0, 32'hFFFF_FFFE);
        single("slt", OP_SLT, 32'h8000_0000, 32'h1, 5'd0, 16'h0, 32'h1);
        single("sltu", OP_SLTU, 32'h8000_0000, 32'h1, 5'd0, 16'h0, 32'h0);
        single("srav", OP_SRAV, 32'h4, 32'h8000_0000, 5'd0, 16'h0, 32'hF800_0000);
        single("lui", OP_LUI, 32'h0, 32'h0, 5'd0, 16'h1234, 32'h1234_0000);
        single("sll", OP_SLL, 32'h0, 32'h1, 5'd31, 16'h0, 32'h8000_0000);
        single("nor", OP_NOR, 32'h0, 32'h0, 5'd0, 16'h0, 32'hFFFF_FFFF);
        single("undef", OP_UNDEF, 32'h1234, 32'h5678, 5'd3, 16'h0, 32'h0);

        multi("mult", OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        single("mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 32'hFFFF_FFFF);
        single("mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 16'h0, 32'hFFFF_FFFA);
        multi("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        multi("div", OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        multi("divu0", OP_DIVU, 32'h7, 32'h0, 1'b0, 32'h7, 32'hFFFF_FFFF);
        multi("div0neg", OP_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        multi("divmin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        multi("divu hold", OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);

        single("mthi", OP_MTHI, 32'hAAAA_5555, 32'h0, 5'd0, 16'h0, 32'hAAAA_5555);
        chk("mthi hi", hi, 32'hAAAA_5555);
        chk("mthi lo untouched", lo, 32'd14);

        // Reset at RUN iteration 10 aborts the multiply.
        ALUop = OP_MULTU; busA = 32'h1234_5678; B = 32'h9ABC_DEF0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk1("abort busy before reset", busy, 1'b1);
        reset = 1'b1;
        step();
        chk1("abort out_valid", out_valid, 1'b0);
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h0);
        chk1("abort in_ready", in_ready, 1'b1);
        reset = 1'b0;
        single("post reset mtlo", OP_MTLO, 32'h0000_BEEF, 32'h0, 5'd0, 16'h0, 32'h0000_BEEF);
        chk("post reset lo", lo, 32'h0000_BEEF);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid) pulses++;
        end
        chk("abort no late pulse", pulses, 32'd0);
        chk("post reset hi", hi, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width; legal values are powers of two, 16 or more.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  meaning an operation is offered.
REQ-006 The block SHALL have port in_ready  output  1  meaning an operation can be accepted; in_ready = !busy.
REQ-007 The block SHALL have port ALUop  input  5  meaning operation code.
REQ-008 The block SHALL have port busA  input  WIDTH  meaning operand A.
REQ-009 The block SHALL have port B  input  WIDTH  meaning operand B.
REQ-010 The block SHALL have port shf  input  SHW  meaning shift amount.
REQ-011 The block SHALL have port immediate  input  16  meaning LUI immediate.
REQ-012 The block SHALL have port out_valid  output  1  meaning a one-cycle pulse; result, zero, hi and lo are valid.
REQ-013 The block SHALL have port result  output  WIDTH  meaning registered result.
REQ-014 The block SHALL have port zero  output  1  meaning registered flag, 1 when result is 0.
REQ-015 The block SHALL have port busy  output  1  meaning a multiply or divide is in progress.
REQ-016 The block SHALL have ports hi and lo  output  WIDTH  meaning the HI and LO registers.

Function
REQ-017 An operation SHALL be accepted in a cycle where in_valid and in_ready are both 1; in_valid SHALL be ignored while busy is 1.
REQ-018 Single-cycle ops SHALL be encoded as follows: 00000 ADD; 00001 SUB; 00010 XOR; 00011 OR; 00100 AND; 00101 SLTU (busA<B unsigned); 00110 NOR; 00111 B<<shf; 01000 B>>shf logical; 01001 {immediate, WIDTH-16 zeros}; 01010 B<<busA[SHW-1:0]; 01011 B>>>shf arithmetic; 01100 B>>>busA[SHW-1:0]; 01101 SLT signed; 01111 B>>busA[SHW-1:0] logical; 10100 MFHI (result=hi); 10101 MFLO (result=lo); 10110 MTHI (hi<=busA, result=busA); 10111 MTLO (lo<=busA, result=busA).
REQ-019 Any unlisted code SHALL produce result 0 with out_valid.
REQ-020 ADD and SUB SHALL wrap modulo 2^WIDTH with no overflow trap.
REQ-021 Single-cycle ops SHALL have latency 1: accepted at cycle t, then result, zero and out_valid are registered at t+1.
REQ-022 Multi-cycle ops SHALL be encoded as follows: 10000 MULTU; 10001 MULT; 10010 DIVU; 10011 DIV.
REQ-023 The FSM SHALL have states IDLE, RUN and FIN. IDLE goes to RUN on acceptance of a multi-cycle op. RUN performs exactly WIDTH iterations: one shift-add per cycle for multiply, one restoring-subtract per cycle for divide. RUN goes to FIN after the last iteration. FIN goes to IDLE after one cycle.
REQ-024 busy SHALL be 1 in RUN and FIN, so in_ready is 0 from t+1 to t+WIDTH+1.
REQ-025 In FIN, out_valid SHALL be 1; hi and lo SHALL be written in the same cycle; result SHALL equal the new lo and zero SHALL follow result. Latency SHALL be WIDTH+1 cycles from acceptance to out_valid.
REQ-026 Multiply SHALL produce the full 2*WIDTH-bit product as {hi,lo}. MULT SHALL treat the operands as two's complement.
REQ-027 Divide SHALL produce lo = quotient and hi = remainder. For DIV the quotient truncates toward zero and the remainder takes the sign of busA.
REQ-028 Divide by zero SHALL give lo = all ones and hi = busA, for both DIVU and DIV.
REQ-029 DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0.
REQ-030 Operands for multi-cycle ops SHALL be captured at acceptance; input changes during RUN SHALL have no effect.
REQ-031 hi and lo SHALL change only in FIN, on MTHI/MTLO, or on reset.
REQ-032 MFHI/MFLO accepted at cycle t+WIDTH+2, the first cycle in_ready returns after a multiply, SHALL return the new hi/lo values.
REQ-033 out_valid SHALL be 0 in every cycle with no completing operation; result and zero SHALL hold their last values.

Reset
REQ-034 While reset is 1 at a clock edge, the block SHALL set: state IDLE; busy 0; in_ready 1; out_valid 0; result 0; zero 1; hi 0; lo 0.
REQ-035 Reset SHALL take priority over acceptance and over any RUN or FIN activity; an in-flight multiply or divide SHALL be aborted with no out_valid pulse.
REQ-036 The first operation after reset SHALL be acceptable in the cycle after reset deasserts.

Verification
REQ-037 The bench SHALL cover, with WIDTH=32: ADD busA=FFFFFFFF, B=1 -> next cycle out_valid=1, result=0, zero=1.
REQ-038 The bench SHALL cover: SLT busA=80000000, B=1 -> result=1; SLTU with the same operands -> result=0; SRAV with B=80000000 and busA=4 -> result=F8000000.
REQ-039 The bench SHALL cover: MULT busA=FFFFFFFE (-2), B=3 -> in_ready=0 for 33 cycles, out_valid at t+33, hi=FFFFFFFF, lo=FFFFFFFA; then MFHI -> result FFFFFFFF.
REQ-040 The bench SHALL cover: DIV busA=FFFFFFF9 (-7), B=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 7/0 -> lo=FFFFFFFF, hi=7.
REQ-041 The bench SHALL cover: in_valid held high with ADD during a DIVU -> no extra acceptance, only the DIVU out_valid pulse; the ADD is accepted at t+34.
REQ-042 The bench SHALL cover: reset asserted at iteration 10 of a MULTU -> no out_valid pulse, hi=lo=0, in_ready=1 after reset.
